// File: rtl/read_domain_ptr_sync_if.sv
// Read-domain pointer synchronizer bus: asynchronous Gray write pointer in,
// synchronized Gray/binary pointer, change strobe and status flags out.
interface read_domain_ptr_sync_if #(
  parameter int ADDRESS_SIZE = 4
);
  localparam int W = ADDRESS_SIZE + 1;

  // Strobe semantics, no back-pressure: wptr_changed is a one-cycle strobe in
  // the rclk domain, meaningful only while sync_valid is high; there is no
  // ready, so a consumer must sample it on the cycle it is asserted.
  logic [W-1:0] wptr_gray;
  logic         err_clr;
  logic [W-1:0] wptr_gray_sync;
  logic [W-1:0] wptr_bin_sync;
  logic         wptr_changed;
  logic         sync_valid;
  logic         gray_err;

  modport master (
    output wptr_gray,
    output err_clr,
    input  wptr_gray_sync,
    input  wptr_bin_sync,
    input  wptr_changed,
    input  sync_valid,
    input  gray_err
  );

  modport slave (
    input  wptr_gray,
    input  err_clr,
    output wptr_gray_sync,
    output wptr_bin_sync,
    output wptr_changed,
    output sync_valid,
    output gray_err
  );
endinterface

// File: rtl/read_domain_ptr_sync.sv
// N-stage Gray write-pointer synchronizer for the async FIFO read domain.
// Define GRAY_PTR_CHECK_EN to build the sticky multi-bit-change checker.
module read_domain_ptr_sync #(
  parameter int ADDRESS_SIZE = 4,
  parameter int SYNC_STAGES  = 2
) (
  input logic                    rclk,
  input logic                    rreset,
  read_domain_ptr_sync_if.slave  bus
);

  localparam int W      = ADDRESS_SIZE + 1;
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW     = $clog2(STAGES + 2);
  localparam logic [CW-1:0] LAST = CW'(STAGES + 1);

  logic [W-1:0]  stage_q [STAGES];
  logic [W-1:0]  gray_prev_q;
  logic [W-1:0]  bin_d;
  logic [W-1:0]  bin_q;
  logic          changed_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic [W-1:0]  gray_sync;

  assign gray_sync = stage_q[STAGES-1];

  // Plain flop chain: nothing combinational between stages.
  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= bus.wptr_gray;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    bin_d        = '0;
    bin_d[W-1]   = gray_sync[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ gray_sync[i];
    end
  end

  // Saturating warm-up count; valid is registered from the next count so it
  // rises on the (STAGES+1)th edge after reset release.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      gray_prev_q <= '0;
      bin_q       <= '0;
      changed_q   <= 1'b0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      gray_prev_q <= gray_sync;
      bin_q       <= bin_d;
      changed_q   <= (gray_sync != gray_prev_q);
      cnt_q       <= cnt_d;
      valid_q     <= (cnt_d == LAST);
    end
  end

  assign bus.wptr_gray_sync = gray_sync;
  assign bus.wptr_bin_sync  = bin_q;
  assign bus.wptr_changed   = changed_q;
  assign bus.sync_valid     = valid_q;

`ifdef GRAY_PTR_CHECK_EN
  logic [W-1:0] diff;
  logic         multi_bit;
  logic         err_set;
  logic         err_d;
  logic         err_q;

  // diff & (diff - 1) is nonzero exactly when more than one bit differs.
  always_comb begin
    diff      = gray_sync ^ gray_prev_q;
    multi_bit = |(diff & (diff - W'(1)));
    err_set   = valid_q & multi_bit;
    err_d     = err_set | (err_q & ~bus.err_clr);
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.gray_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.gray_err   = 1'b0;
`endif

endmodule

// File: tb/tb_read_domain_ptr_sync.sv
// Bench for read_domain_ptr_sync: three instances (SYNC_STAGES 2, 4, 1->2)
// checked against a cycle-history reference model plus fixed vector tables.
module tb_read_domain_ptr_sync;

  localparam int AS = 4;
  localparam int W  = AS + 1;
`ifdef GRAY_PTR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int eff [3] = '{2, 4, 2};

  logic rclk = 1'b0;
  logic rreset = 1'b1;

  // clock/reset block
  always #5 rclk = ~rclk;

  read_domain_ptr_sync_if #(.ADDRESS_SIZE(AS)) b2 ();
  read_domain_ptr_sync_if #(.ADDRESS_SIZE(AS)) b4 ();
  read_domain_ptr_sync_if #(.ADDRESS_SIZE(AS)) b1 ();

  read_domain_ptr_sync #(.ADDRESS_SIZE(AS), .SYNC_STAGES(2)) u_s2 (
    .rclk(rclk), .rreset(rreset), .bus(b2));
  read_domain_ptr_sync #(.ADDRESS_SIZE(AS), .SYNC_STAGES(4)) u_s4 (
    .rclk(rclk), .rreset(rreset), .bus(b4));
  read_domain_ptr_sync #(.ADDRESS_SIZE(AS), .SYNC_STAGES(1)) u_s1 (
    .rclk(rclk), .rreset(rreset), .bus(b1));

  logic [W-1:0] o_sync [3];
  logic [W-1:0] o_bin  [3];
  logic         o_chg  [3];
  logic         o_val  [3];
  logic         o_err  [3];

  assign o_sync[0] = b2.wptr_gray_sync;  assign o_sync[1] = b4.wptr_gray_sync;
  assign o_sync[2] = b1.wptr_gray_sync;
  assign o_bin[0]  = b2.wptr_bin_sync;   assign o_bin[1]  = b4.wptr_bin_sync;
  assign o_bin[2]  = b1.wptr_bin_sync;
  assign o_chg[0]  = b2.wptr_changed;    assign o_chg[1]  = b4.wptr_changed;
  assign o_chg[2]  = b1.wptr_changed;
  assign o_val[0]  = b2.sync_valid;      assign o_val[1]  = b4.sync_valid;
  assign o_val[2]  = b1.sync_valid;
  assign o_err[0]  = b2.gray_err;        assign o_err[1]  = b4.gray_err;
  assign o_err[2]  = b1.gray_err;

  int checks = 0;
  int errors = 0;

  // reference model state: input seen at each edge since reset release
  logic [W-1:0] in_hist [int];
  int           edge_n = 0;
  logic         err_m [3] = '{1'b0, 1'b0, 1'b0};
  int           pulses [3] = '{0, 0, 0};

  function automatic logic [W-1:0] in_at(int e);
    if (e >= 1 && in_hist.exists(e)) return in_hist[e];
    return '0;
  endfunction

  function automatic logic [W-1:0] sync_at(int s, int e);
    return in_at(e - s + 1);
  endfunction

  function automatic logic [W-1:0] to_bin(logic [W-1:0] g);
    logic [W-1:0] b = '0;
    for (int k = 0; k < W; k++) b ^= (g >> k);
    return b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 3; d++) begin
      int s = eff[d];
      chk($sformatf("sync[u%0d]", d), 32'(o_sync[d]), 32'(sync_at(s, edge_n)));
      chk($sformatf("bin[u%0d]", d), 32'(o_bin[d]),
          32'((edge_n >= 1) ? to_bin(sync_at(s, edge_n - 1)) : '0));
      chk($sformatf("chg[u%0d]", d), 32'(o_chg[d]),
          32'((edge_n >= 1) && (sync_at(s, edge_n - 1) != sync_at(s, edge_n - 2))));
      chk($sformatf("valid[u%0d]", d), 32'(o_val[d]), 32'(edge_n >= s + 1));
      chk($sformatf("err[u%0d]", d), 32'(o_err[d]), 32'(err_m[d]));
    end
  endtask

  // driver: present inputs away from the edge, clock once, update model, check
  task automatic tick(logic [W-1:0] g, logic clr);
    b2.wptr_gray = g; b4.wptr_gray = g; b1.wptr_gray = g;
    b2.err_clr = clr; b4.err_clr = clr; b1.err_clr = clr;
    @(posedge rclk);
    edge_n++;
    in_hist[edge_n] = g;
    for (int d = 0; d < 3; d++) begin
      int  s = eff[d];
      logic set = CHK && (edge_n - 1 >= s + 1) &&
                  ($countones(sync_at(s, edge_n - 1) ^ sync_at(s, edge_n - 2)) > 1);
      err_m[d] = set | (err_m[d] & ~clr);
    end
    #1;
    for (int d = 0; d < 3; d++) pulses[d] += int'(o_chg[d]);
    check_model();
  endtask

  task automatic do_reset();
    rreset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_sync[u%0d]", d), 32'(o_sync[d]), 32'(0));
      chk($sformatf("rst_bin[u%0d]", d), 32'(o_bin[d]), 32'(0));
      chk($sformatf("rst_chg[u%0d]", d), 32'(o_chg[d]), 32'(0));
      chk($sformatf("rst_valid[u%0d]", d), 32'(o_val[d]), 32'(0));
      chk($sformatf("rst_err[u%0d]", d), 32'(o_err[d]), 32'(0));
    end
    @(posedge rclk);
    @(negedge rclk);
    rreset = 1'b0;
    edge_n = 0;
    in_hist.delete();
    err_m = '{1'b0, 1'b0, 1'b0};
  endtask

  function automatic logic [W-1:0] gray_of(int b);
    logic [W-1:0] v = W'(b);
    return v ^ (v >> 1);
  endfunction

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] s2_sync;
    logic [W-1:0] s2_bin;
    logic         s2_chg;
    logic         s2_valid;
    logic [W-1:0] s4_sync;
    logic         s4_chg;
    logic         s4_valid;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[2] = '{5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
    tbl[3] = '{5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
    tbl[4] = '{5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1};
    tbl[5] = '{5'd1, 5'd1, 5'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1};
    tbl[6] = '{5'd3, 5'd1, 5'd1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1};
    tbl[7] = '{5'd3, 5'd3, 5'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1};
    tbl[8] = '{5'd3, 5'd3, 5'd2, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1};
    tbl[9] = '{5'd3, 5'd3, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1};

    b2.wptr_gray = '0; b4.wptr_gray = '0; b1.wptr_gray = '0;
    b2.err_clr = 1'b0; b4.err_clr = 1'b0; b1.err_clr = 1'b0;

    // warm-up and first pointer changes from a fixed vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].gray, 1'b0);
      chk($sformatf("tbl%0d_s2_sync", i), 32'(o_sync[0]), 32'(tbl[i].s2_sync));
      chk($sformatf("tbl%0d_s2_bin", i), 32'(o_bin[0]), 32'(tbl[i].s2_bin));
      chk($sformatf("tbl%0d_s2_chg", i), 32'(o_chg[0]), 32'(tbl[i].s2_chg));
      chk($sformatf("tbl%0d_s2_valid", i), 32'(o_val[0]), 32'(tbl[i].s2_valid));
      chk($sformatf("tbl%0d_s1_bin", i), 32'(o_bin[2]), 32'(tbl[i].s2_bin));
      chk($sformatf("tbl%0d_s4_sync", i), 32'(o_sync[1]), 32'(tbl[i].s4_sync));
      chk($sformatf("tbl%0d_s4_chg", i), 32'(o_chg[1]), 32'(tbl[i].s4_chg));
      chk($sformatf("tbl%0d_s4_valid", i), 32'(o_val[1]), 32'(tbl[i].s4_valid));
    end

    // full Gray count including wrap 10000 -> 00000
    do_reset();
    for (int i = 0; i < 6; i++) tick('0, 1'b0);
    pulses = '{0, 0, 0};
    for (int b = 1; b <= 32; b++) begin
      for (int r = 0; r < 3; r++) tick(gray_of(b % 32), 1'b0);
    end
    for (int i = 0; i < 6; i++) tick('0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pulse_count[u%0d]", d), 32'(pulses[d]), 32'd32);
      chk($sformatf("count_err[u%0d]", d), 32'(o_err[d]), 32'd0);
      chk($sformatf("count_bin_end[u%0d]", d), 32'(o_bin[d]), 32'd0);
    end

`ifdef GRAY_PTR_CHECK_EN
    // two-bit jump sets, err_clr alone clears, set beats a same-cycle clear
    tick(5'b00011, 1'b0);
    tick(5'b00011, 1'b0);
    tick(5'b00011, 1'b0);
    chk("err_set_s2", 32'(o_err[0]), 32'd1);
    tick(5'b00011, 1'b0);
    tick(5'b00011, 1'b0);
    chk("err_held_s2", 32'(o_err[0]), 32'd1);
    tick(5'b00011, 1'b1);
    chk("err_clr_s2", 32'(o_err[0]), 32'd0);
    tick(5'b00000, 1'b0);
    tick(5'b00000, 1'b0);
    tick(5'b00000, 1'b1);
    chk("err_set_wins_s2", 32'(o_err[0]), 32'd1);
    for (int i = 0; i < 4; i++) tick('0, 1'b0);
`endif

    // mid-stream reset with a nonzero pointer present
    for (int i = 0; i < 5; i++) tick(5'b01101, 1'b0);
    do_reset();
    tick(5'b01101, 1'b0);
    chk("rel_e1_valid", 32'(o_val[0]), 32'd0);
    tick(5'b01101, 1'b0);
    chk("rel_e2_valid", 32'(o_val[0]), 32'd0);
    tick(5'b01101, 1'b0);
    chk("rel_e3_bin", 32'(o_bin[0]), 32'b01001);
    chk("rel_e3_chg", 32'(o_chg[0]), 32'd1);
    chk("rel_e3_valid", 32'(o_val[0]), 32'd1);
    tick(5'b01101, 1'b0);
    chk("rel_e4_chg", 32'(o_chg[0]), 32'd0);

    // randomized walk: Gray steps, holds, arbitrary jumps, clears, resets
    begin
      int bcnt = 13;
      for (int n = 0; n < 600; n++) begin
        int sel = $urandom_range(0, 99);
        if (sel < 2) begin
          do_reset();
        end else if (sel < 50) begin
          bcnt = (bcnt + 1) % 32;
        end else if (sel < 65) begin
          bcnt = (bcnt + 31) % 32;
        end else if (sel < 75) begin
          bcnt = $urandom_range(0, 31);
        end
        tick(gray_of(bcnt), ($urandom_range(0, 7) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_domain_ptr_sync.md
Name: read_domain_ptr_sync

Overview:
Parametrised N-stage Gray-pointer synchronizer for the async FIFO read domain. Brings the write pointer (Gray, ADDRESS_SIZE+1 bits) into rclk with configurable depth. Also provides a registered binary version, a pointer-advanced pulse and a post-reset valid flag. Optionally checks that the sync'd Gray stream changes by at most one bit per rclk cycle. Feeds the read-side empty/almost-empty logic.

Parameters:
ADDRESS_SIZE, 4, FIFO address bits; pointer width = ADDRESS_SIZE+1
SYNC_STAGES, 2, number of synchronizer flops; legal 2..8; values <2 are treated as 2

Ports:
rclk  input  1  read-domain clock; all flops rising-edge
rreset  input  1  asynchronous, active-high reset; clears all state immediately
wptr_gray  input  ADDRESS_SIZE+1  write pointer, Gray coded, from wclk domain (asynchronous)
err_clr  input  1  synchronous clear of gray_err
wptr_gray_sync  output  ADDRESS_SIZE+1  synchronized Gray pointer (last sync stage)
wptr_bin_sync  output  ADDRESS_SIZE+1  registered binary of wptr_gray_sync
wptr_changed  output  1  one-cycle pulse, aligned with wptr_bin_sync update
sync_valid  output  1  high once the sync chain has flushed after reset
gray_err  output  1  sticky multi-bit-change error (feature-dependent)

Behaviour:
- Sync chain: stage[0] <= wptr_gray; stage[i] <= stage[i-1]; wptr_gray_sync = stage[SYNC_STAGES-1]. Latency SYNC_STAGES rclk edges. No logic between stages.
- gray_prev <= wptr_gray_sync every cycle.
- wptr_bin_sync <= gray2bin(wptr_gray_sync). Bit MSB = g[MSB]; bit i = b[i+1] XOR g[i]. Latency SYNC_STAGES+1.
- wptr_changed <= (wptr_gray_sync != gray_prev). High in the same cycle wptr_bin_sync shows the new value; lasts exactly one cycle per change. Back-to-back changes give consecutive pulses.
- Wrap-around: Gray 10000 -> 00000 (ADDRESS_SIZE=4) is a legal single-bit change. Binary goes 11111 -> 00000 with a normal pulse. No special casing.
- Warm-up counter: width ceil(log2(SYNC_STAGES+2)). Counts from 0 after reset and saturates at SYNC_STAGES+1. sync_valid = (count == SYNC_STAGES+1), registered. Goes high on the (SYNC_STAGES+1)th rising edge after reset deassertion and stays high until the next reset.
- Reset, asserted at any time including mid-stream: all stages, gray_prev, wptr_bin_sync, wptr_changed, counter, sync_valid and gray_err go to 0 asynchronously. After release, the chain refills from wptr_gray and sync_valid restarts from 0.
- wptr_changed is not gated by sync_valid. It can fire during warm-up if wptr_gray is nonzero at reset release. Consumers qualify with sync_valid.
- Reset values of all outputs: 0.

Optional Feature:
Macro GRAY_PTR_CHECK_EN.
- Defined: popcount(wptr_gray_sync XOR gray_prev) > 1 sets gray_err on the next edge. Only evaluated when sync_valid=1. gray_err is sticky until err_clr. If set and clear occur in the same cycle, set wins. Reset clears it.
- Not defined: gray_err is constant 0, err_clr is ignored, and no comparison logic is synthesized. All other behaviour is identical.

Test Plan:
1. ADDRESS_SIZE=4, SYNC_STAGES=2, wptr_gray=0, release rreset -> sync_valid 0 after edges 1-2, 1 from edge 3 on; all other outputs 0.
2. wptr_gray 00000->00001 before edge k -> wptr_gray_sync=00001 after edge k+1. After edge k+2: wptr_bin_sync=00001, wptr_changed=1 for exactly one cycle.
3. Drive Gray count for binary 0..31 then 0, one step every 3 cycles -> wptr_bin_sync follows 0..31,0 (11111->00000 on wrap); 32 single-cycle wptr_changed pulses; gray_err stays 0.
4. GRAY_PTR_CHECK_EN defined, sync_valid=1, wptr_gray 00000->00011 -> gray_err=1, held. err_clr alone -> 0. err_clr together with a new 2-bit jump -> stays 1.
5. Assert rreset mid-count (wptr_gray=01101) -> all outputs 0 immediately. On release: sync_valid low for 2 edges; wptr_bin_sync=01001 three edges after release, with one wptr_changed pulse.
6. SYNC_STAGES=4 rerun of test 2 -> wptr_gray_sync after edge k+3, binary/pulse after edge k+4, sync_valid from edge 5.
